// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard control slice.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Instruction injected by a register flush (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // DatatoReg write-back select; the memory encoding marks a load.
  localparam logic [1:0] DATATOREG_ALU = 2'b00;
  localparam logic [1:0] DATATOREG_MEM = 2'b01;

  // True when a used source register matches a destination register.
  function automatic logic src_hit(input logic       use_src,
                                   input logic [4:0] src,
                                   input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator between the ID and EXE stages.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_regwrite,
  output logic       lu
);

  // A load writing a non-zero register that ID reads must be waited for.
  always_comb begin
    lu = ex_is_load && ex_regwrite && (ex_rd != '0) &&
         (src_hit(id_use_rs1, id_rs1, ex_rd) || src_hit(id_use_rs2, id_rs2, ex_rd));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch redirects, and a memory-wait FSM with timeout.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_regwrite,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_ce,
  output logic             if_id_ce,
  output logic             if_id_flush,
  output logic             id_exe_ce,
  output logic             id_exe_flush,
  output logic             exe_mem_ce,
  output logic             mem_wb_ce,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu;
  logic              freeze;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_regwrite (ex_regwrite),
    .lu          (lu)
  );

  // Outstanding data-memory access (or a dead memory) holds every stage.
  always_comb begin
    freeze = ((state == RUN) && mem_req && !mem_ready) ||
             ((state == MEM_WAIT) && !mem_ready) ||
             (state == ERR);
  end

  // Stage enables and flushes; freeze wins, then branch, then load-use.
  always_comb begin
    pc_ce        = 1'b0;
    if_id_ce     = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_ce    = 1'b0;
    id_exe_flush = 1'b0;
    exe_mem_ce   = 1'b0;
    mem_wb_ce    = 1'b0;
    if (!rst && !freeze) begin
      pc_ce      = 1'b1;
      if_id_ce   = 1'b1;
      id_exe_ce  = 1'b1;
      exe_mem_ce = 1'b1;
      mem_wb_ce  = 1'b1;
      if (br_taken) begin
        // ID holds a wrong-path instruction, so its load-use match is moot.
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (lu) begin
        pc_ce        = 1'b0;
        if_id_ce     = 1'b0;
        id_exe_flush = 1'b1;
      end
    end
  end

  // Memory wait FSM with timeout into a sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt + 1'b1 == TIMEOUT_V) begin
              state   <= ERR;
              mem_err <= 1'b1;
            end
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

  // Performance counters: stalled PC cycles and applied redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_ce) stall_cnt <= stall_cnt + 1'b1;
      if (!freeze && br_taken) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_regwrite;
  logic        br_taken, mem_req, mem_ready;
  logic        pc_ce, if_id_ce, if_id_flush, id_exe_ce, id_exe_flush;
  logic        exe_mem_ce, mem_wb_ce, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_regwrite  (ex_regwrite),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_ce        (pc_ce),
    .if_id_ce     (if_id_ce),
    .if_id_flush  (if_id_flush),
    .id_exe_ce    (id_exe_ce),
    .id_exe_flush (id_exe_flush),
    .exe_mem_ce   (exe_mem_ce),
    .mem_wb_ce    (mem_wb_ce),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // ce vector order: {pc_ce, if_id_ce, if_id_flush, id_exe_ce, id_exe_flush, exe_mem_ce, mem_wb_ce}
  localparam logic [6:0] CE_ZERO = 7'b0000000;
  localparam logic [6:0] CE_ALL  = 7'b1101011;
  localparam logic [6:0] CE_LU   = 7'b0001111;
  localparam logic [6:0] CE_BR   = 7'b1111111;

  typedef struct packed {
    logic [6:0]  ce;
    logic        err;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: the DUT presents a response every cycle; compare when one is expected.
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t  e;
      string n;
      e = eq.pop_front();
      n = nq.pop_front();
      chk({n, ".ce"},    {25'd0, pc_ce, if_id_ce, if_id_flush, id_exe_ce, id_exe_flush,
                          exe_mem_ce, mem_wb_ce}, {25'd0, e.ce});
      chk({n, ".err"},   {31'd0, mem_err}, {31'd0, e.err});
      chk({n, ".stall"}, stall_cnt, e.sc);
      chk({n, ".flush"}, flush_cnt, e.fc);
    end
  end

  task automatic expect_cyc(string name, logic [6:0] ce, logic err, int sc, int fc);
    exp_t e;
    e.ce = ce; e.err = err; e.sc = 32'(sc); e.fc = 32'(fc);
    eq.push_back(e);
    nq.push_back(name);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_regwrite = 1'b0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(logic [4:0] rd, logic ld, logic rw, logic [4:0] rs1, logic u1,
                        logic [4:0] rs2, logic u2);
    ex_rd = rd; ex_is_load = ld; ex_regwrite = rw;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    expect_cyc("reset", CE_ZERO, 1'b0, 0, 0);
    rst = 1'b0;
    expect_cyc("idle", CE_ALL, 1'b0, 0, 0);

    // Load-use variants
    set_lu(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    expect_cyc("lu_rs2", CE_LU, 1'b0, 0, 0);
    idle();
    expect_cyc("lu_after", CE_ALL, 1'b0, 1, 0);
    set_lu(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    expect_cyc("lu_rd0", CE_ALL, 1'b0, 1, 0);
    set_lu(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    expect_cyc("lu_norw", CE_ALL, 1'b0, 1, 0);
    set_lu(5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1);
    expect_cyc("lu_rs1", CE_LU, 1'b0, 1, 0);
    set_lu(5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 5'd3, 1'b1);
    expect_cyc("lu_unused", CE_ALL, 1'b0, 2, 0);

    // Branch overrides load-use
    set_lu(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    br_taken = 1'b1;
    expect_cyc("br_lu", CE_BR, 1'b0, 2, 0);
    idle();
    expect_cyc("br_after", CE_ALL, 1'b0, 2, 1);

    // Three-cycle memory wait
    mem_req = 1'b1;
    expect_cyc("mw1", CE_ZERO, 1'b0, 2, 1);
    expect_cyc("mw2", CE_ZERO, 1'b0, 3, 1);
    expect_cyc("mw3", CE_ZERO, 1'b0, 4, 1);
    mem_ready = 1'b1;
    expect_cyc("mw_release", CE_ALL, 1'b0, 5, 1);
    idle();
    expect_cyc("mw_after", CE_ALL, 1'b0, 5, 1);

    // Branch pending while frozen, applied on release
    mem_req = 1'b1; br_taken = 1'b1;
    expect_cyc("brf1", CE_ZERO, 1'b0, 5, 1);
    expect_cyc("brf2", CE_ZERO, 1'b0, 6, 1);
    mem_ready = 1'b1;
    expect_cyc("brf_release", CE_BR, 1'b0, 7, 1);
    idle();
    expect_cyc("brf_after", CE_ALL, 1'b0, 7, 2);

    // Zero-wait access
    mem_req = 1'b1; mem_ready = 1'b1;
    expect_cyc("zero_wait", CE_ALL, 1'b0, 7, 2);
    idle();
    expect_cyc("zw_after", CE_ALL, 1'b0, 7, 2);

    // Timeout: 16 frozen cycles, then ERR
    mem_req = 1'b1;
    for (int j = 0; j < 16; j++) expect_cyc("to_wait", CE_ZERO, 1'b0, 7 + j, 2);
    expect_cyc("err_entry", CE_ZERO, 1'b1, 23, 2);
    mem_ready = 1'b1;
    expect_cyc("err_sticky", CE_ZERO, 1'b1, 24, 2);
    expect_cyc("err_sticky2", CE_ZERO, 1'b1, 25, 2);

    // Asynchronous reset out of ERR
    rst = 1'b1;
    idle();
    expect_cyc("rst_pulse", CE_ZERO, 1'b0, 0, 0);
    rst = 1'b0;
    expect_cyc("post_rst", CE_ALL, 1'b0, 0, 0);

    // Reset mid-MEM_WAIT
    mem_req = 1'b1;
    expect_cyc("mwr1", CE_ZERO, 1'b0, 0, 0);
    expect_cyc("mwr2", CE_ZERO, 1'b0, 1, 0);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    idle();
    @(posedge clk); #1;
    expect_cyc("mwr_after", CE_ALL, 1'b0, 0, 0);

    for (int k = 0; k < 10 && eq.size() > 0; k++) @(negedge clk);
    if (eq.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
